// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM state encodings
// and the ceiling-log2 helper used to size bit counters.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Smallest r such that 2**r >= n (returns 0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// One-bit full adder cell; the only arithmetic in the serial adder.
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through a single
// FullAdder cell, with the cell carry registered and fed back each cycle.
// Valid/ready on both sides; one add every WIDTH+2 cycles at best.
// Optional macro BIT_SERIAL_ADDER_OVF_EN adds a registered signed-overflow
// output (carry into MSB xor carry out), valid together with out_valid.
module bit_serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef BIT_SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CNT_RAW = clog2(WIDTH);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             cout_q;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic             ovf_q;
`endif

  assign accept = in_valid & in_ready;

  FullAdder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Operand shift registers: loaded on accept, shifted right while running.
  // Pure data, so no reset; their contents are only consumed in RUN.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && accept) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == ST_RUN) begin
      a_sh <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh <= {1'b0, b_sh[WIDTH-1:1]};
    end
  end

  // Control FSM with carry flop, bit counter, sum shift register and
  // registered handshake/result outputs. The state change on the last bit
  // stops the counter, so it never needs to wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum_sh    <= '0;
      cout_q    <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
          carry  <= fa_cout;
          if (cnt == LAST_BIT) begin
            // carry currently holds the carry into the MSB position.
            cout_q    <= fa_cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            ovf_q     <= carry ^ fa_cout;
`endif
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign sum  = sum_sh;
  assign cout = cout_q;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8): table of directed
// vectors, hand sequences for backpressure and mid-run reset, and a random
// sweep, all checked through an expected-result queue.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef BIT_SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic or_ctl   = 1'b1;
  logic rnd_or   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Drive one operand set and wait (bounded) for it to be accepted; the
  // expected result is queued at the accept edge, then operands are scrambled.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    int   n;
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    n = 0;
    while (!(in_ready && !rst) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("accept_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
      return;
    end
    e.s = es; e.c = ec; e.o = eo; e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  // Output-side monitor: drives out_ready, checks latency on out_valid rise,
  // checks result at each handshake and that out_valid drops afterwards.
  initial begin
    logic ov_prev;
    logic expect_low;
    exp_t e;
    ov_prev    = 1'b0;
    expect_low = 1'b0;
    out_ready  = 1'b0;
    forever begin
      @(negedge clk);
      if (expect_low) begin
        chk("out_valid_one_shot", 32'(out_valid), 32'd0);
        expect_low = 1'b0;
      end
      out_ready = rnd_or ? ($urandom_range(0, 3) != 0) : or_ctl;
      if (!rst) begin
        if (out_valid && !ov_prev) begin
          if (q.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
          else chk("latency", 32'(cyc - q[0].acc), 32'(W));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("result_no_expect", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
`ifdef BIT_SERIAL_ADDER_OVF_EN
            chk("result", {22'd0, ovf, cout, sum}, {22'd0, e.o, e.c, e.s});
`else
            chk("result", {23'd0, cout, sum}, {23'd0, e.c, e.s});
`endif
            expect_low = 1'b1;
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  initial begin
    vec_t vt[11];
    int   n;
    logic [W:0]   t;
    logic [W-1:0] ra, rb;
    logic         rc, ro;

    vt[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2]  = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
    vt[3]  = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
    vt[4]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[5]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[6]  = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[7]  = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[8]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[9]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
    vt[10] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);

    // Directed vectors, consumer always ready
    or_ctl = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].c, vt[i].o);
      drain();
    end

    // Backpressure: result held, no new accept until consumed
    or_ctl = 1'b0;
    send(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
      end
      chk("bp_sum_held", 32'(sum), 32'h47);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 or_ctl = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_at_handoff", 32'(in_ready), 32'd0);
    send(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    drain();

    // Reset during RUN cycle 3 discards the partial add
    send(8'hAA, 8'h11, 1'b0, 8'hBB, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    send(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
    drain();

    // Random sweep with random gaps and random consumer readiness
    rnd_or = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      t  = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      ro = (ra[W-1] == rb[W-1]) && (t[W-1] != ra[W-1]);
      send(ra, rb, rc, t[W-1:0], t[W], ro);
    end
    drain();
    rnd_or = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
